fetch_ref_luma_wr: RTL and testbench

Write-side filler for the 96-row x 96-pixel reference luma store in the fetch stage. It takes 16-pixel beats from the external fetch bus over a valid/ready handshake and packs each group of 6 beats into one 96-pixel row. It then drives the store's write port (write enable, 7-bit address, 96-pixel word), placing rows at circular addresses from a programmable start row. Writes yield to the store's read side, which shares the single-port memory.

---
 rtl/fetch_ref_luma_wr_if.sv | 36 +++
 rtl/fetch_ref_luma_wr.sv | 180 ++++++++++++++++++
 tb/tb_fetch_ref_luma_wr.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ref_luma_wr_if.sv
// Fetch-bus beat handshake and reference-store write port shared by the luma store filler.
// slave is the filler's view; master is the view of the bus source / store model.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

interface fetch_ref_luma_wr_if #(
    parameter int BEAT_W = 16 * `PIXEL_WIDTH,
    parameter int ROW_W  = 96 * `PIXEL_WIDTH,
    parameter int ADDR_W = 7
);
    logic              ext_valid_i;
    logic [BEAT_W-1:0] ext_data_i;
    logic              ext_ready_o;
    logic              wrif_en_o;
    logic [ADDR_W-1:0] wrif_addr_o;
    logic [ROW_W-1:0]  wrif_data_o;

    modport slave (
        input  ext_valid_i,
        input  ext_data_i,
        output ext_ready_o,
        output wrif_en_o,
        output wrif_addr_o,
        output wrif_data_o
    );

    modport master (
        output ext_valid_i,
        output ext_data_i,
        input  ext_ready_o,
        input  wrif_en_o,
        input  wrif_addr_o,
        input  wrif_data_o
    );
endinterface

// File: rtl/fetch_ref_luma_wr.sv
// Packs 16-pixel fetch beats into 96-pixel rows and writes them at circular row addresses
// of the reference luma store, yielding to reads. Define REF_LUMA_STAT_EN to add stall_cnt_o.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module fetch_ref_luma_wr #(
    parameter int BEAT_PIX = 16,
    parameter int ROW_PIX  = 96,
    parameter int ROW_NUM  = 96,
    parameter int ADDR_W   = 7
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start_i,
    input  logic [ADDR_W-1:0]  start_row_i,
    input  logic [ADDR_W-1:0]  rows_i,
    input  logic               rd_busy_i,
    fetch_ref_luma_wr_if.slave bus,
    output logic               busy_o,
    output logic               done_o
`ifdef REF_LUMA_STAT_EN
    ,
    output logic [15:0]        stall_cnt_o
`endif
);
    localparam int BEAT_W = BEAT_PIX * `PIXEL_WIDTH;
    localparam int ROW_W  = ROW_PIX * `PIXEL_WIDTH;
    localparam int BEATS  = ROW_PIX / BEAT_PIX;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W:0]   L_ROW_NUM_X = (ADDR_W+1)'(ROW_NUM);
    localparam logic [ADDR_W-1:0] L_ROW_NUM   = ADDR_W'(ROW_NUM);
    localparam logic [BCNT_W-1:0] L_LAST_BEAT = BCNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCNT_W-1:0]  r_beat_cnt;
    logic [ADDR_W-1:0]  r_row_cnt;
    logic [ADDR_W-1:0]  r_start_row;
    logic [ADDR_W-1:0]  r_rows;
    logic [ADDR_W-1:0]  r_addr;
    logic [ROW_W-1:0]   r_row_buf;
    logic [ADDR_W-1:0]  w_rows_clamp;
    logic               w_start;
    logic               w_hs;
    logic               w_last_beat;
    logic               w_wr;
    logic               w_last_row;

    // Sum is one bit wider so a single conditional subtract gives the circular row.
    function automatic logic [ADDR_W-1:0] f_row_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [ADDR_W-1:0] ofs);
        logic [ADDR_W:0] sum;
        sum = {1'b0, base} + {1'b0, ofs};
        if (sum >= L_ROW_NUM_X) begin
            sum = sum - L_ROW_NUM_X;
        end
        return sum[ADDR_W-1:0];
    endfunction

    assign w_rows_clamp = (rows_i > L_ROW_NUM) ? L_ROW_NUM : rows_i;
    assign w_start      = (r_state == ST_IDLE) && start_i;
    assign w_hs         = (r_state == ST_FILL) && bus.ext_valid_i;
    assign w_last_beat  = w_hs && (r_beat_cnt == L_LAST_BEAT);
    assign w_wr         = (r_state == ST_WRITE) && !rd_busy_i;
    assign w_last_row   = (r_row_cnt == (r_rows - ADDR_W'(1)));

    assign bus.ext_ready_o = (r_state == ST_FILL);
    assign bus.wrif_en_o   = w_wr;
    assign bus.wrif_addr_o = r_addr;
    assign bus.wrif_data_o = r_row_buf;
    assign busy_o          = (r_state != ST_IDLE);
    assign done_o          = (r_state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (w_rows_clamp == ADDR_W'(0)) ? ST_DONE : ST_FILL;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_WRITE: begin
                if (w_wr) begin
                    w_state_nxt = w_last_row ? ST_DONE : ST_FILL;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Job latch, beat/row counters; the row address is fixed before WRITE is entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_start_row <= '0;
            r_rows      <= '0;
            r_beat_cnt  <= '0;
            r_row_cnt   <= '0;
            r_addr      <= '0;
        end else if (w_start) begin
            r_start_row <= f_row_addr(start_row_i, ADDR_W'(0));
            r_rows      <= w_rows_clamp;
            r_beat_cnt  <= '0;
            r_row_cnt   <= '0;
        end else if (w_hs) begin
            if (w_last_beat) begin
                r_beat_cnt <= '0;
                r_addr     <= f_row_addr(r_start_row, r_row_cnt);
            end else begin
                r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
            end
        end else if (w_wr && !w_last_row) begin
            r_row_cnt <= r_row_cnt + ADDR_W'(1);
        end
    end

    // Row buffer: beat k fills pixels 16k..16k+15, beat 0 in the MSBs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_row_buf <= '0;
        end else if (w_hs) begin
            for (int k = 0; k < BEATS; k++) begin
                if (r_beat_cnt == BCNT_W'(k)) begin
                    r_row_buf[(BEATS-1-k)*BEAT_W +: BEAT_W] <= bus.ext_data_i;
                end
            end
        end
    end

`ifdef REF_LUMA_STAT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == ST_FILL) && !bus.ext_valid_i) ||
                     ((r_state == ST_WRITE) && rd_busy_i);

    // Saturating count of source-starved and read-blocked cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_start) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_ref_luma_wr.sv
// Scoreboard bench for fetch_ref_luma_wr: stimulus queues expected row writes and done
// pulses, a negedge monitor pops and compares them as the store port shows activity.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_fetch_ref_luma_wr;
    localparam int PW = `PIXEL_WIDTH;
    localparam int BW = 16 * PW;
    localparam int RW = 96 * PW;

    typedef struct {
        logic [6:0]    addr;
        logic [RW-1:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start_i = 1'b0;
    logic [6:0] start_row_i = 7'd0;
    logic [6:0] rows_i = 7'd0;
    logic       rd_busy_i = 1'b0;
    logic       busy_o;
    logic       done_o;
`ifdef REF_LUMA_STAT_EN
    logic [15:0] stall_cnt_o;
`endif

    fetch_ref_luma_wr_if bus();

    fetch_ref_luma_wr dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .start_row_i (start_row_i),
        .rows_i      (rows_i),
        .rd_busy_i   (rd_busy_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef REF_LUMA_STAT_EN
        ,
        .stall_cnt_o (stall_cnt_o)
`endif
    );

    wr_t wq[$];
    int  dq[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  load_id = 0;
    int  lat_exp = 0;
    int  stall_exp_v = -1;
    int  tmo_cnt = 0;
    bit  fin = 1'b0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [BW-1:0] beat_word(input int pat, input int r, input int b);
        logic [BW-1:0] w;
        w = '0;
        for (int p = 0; p < 16; p++) begin
            if (pat == 0) w[(15-p)*PW +: PW] = PW'(b);
            else          w[(15-p)*PW +: PW] = PW'(r*37 + b*16 + p*3 + 1);
        end
        return w;
    endfunction

    function automatic logic [RW-1:0] row_word(input int pat, input int r);
        logic [RW-1:0] w;
        w = '0;
        for (int b = 0; b < 6; b++) w[(5-b)*BW +: BW] = beat_word(pat, r, b);
        return w;
    endfunction

    task automatic send_beat(input logic [BW-1:0] d, input bit gap);
        int n;
        if (gap) begin
            bus.ext_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        bus.ext_valid_i = 1'b1;
        bus.ext_data_i  = d;
        n = 0;
        @(negedge clk);
        while (!bus.ext_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ext_ready_o) begin
            $display("FAIL beat_timeout ready=%b required=1", bus.ext_ready_o);
            tmo_cnt++;
        end
        @(posedge clk); #1;
        bus.ext_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) begin
            $display("FAIL idle_timeout busy=%b required=0", busy_o);
            tmo_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic issue_start(input int srow, input int nrows, input int lat, input int stl);
        start_row_i = 7'(srow);
        rows_i      = 7'(nrows);
        start_i     = 1'b1;
        load_id++;
        start_cyc   = cyc;
        lat_exp     = lat;
        stall_exp_v = stl;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_load(input int srow, input int nrows, input int pat, input bit gap,
                            input int busy_cyc, input int lat, input bit inj, input int stl);
        int  eff;
        wr_t e;
        eff = (nrows > 96) ? 96 : nrows;
        for (int r = 0; r < eff; r++) begin
            e.addr = 7'((srow + r) % 96);
            e.data = row_word(pat, r);
            wq.push_back(e);
        end
        dq.push_back((eff == 0) ? 1 : 0);
        issue_start(srow, nrows, lat, stl);
        for (int r = 0; r < eff; r++) begin
            for (int b = 0; b < 6; b++) begin
                if (inj && r == 1 && b == 2) begin
                    start_row_i = 7'd3;
                    rows_i      = 7'd0;
                    start_i     = 1'b1;
                end
                send_beat(beat_word(pat, r, b), gap && (b != 0));
                start_i = 1'b0;
                if (b == 5 && busy_cyc > 0) begin
                    rd_busy_i = 1'b1;
                    repeat (busy_cyc) @(posedge clk);
                    #1;
                    rd_busy_i = 1'b0;
                end
            end
        end
        wait_idle();
    endtask

    task automatic reset_midload();
        wr_t e;
        for (int r = 0; r < 2; r++) begin
            e.addr = 7'(20 + r);
            e.data = row_word(1, r);
            wq.push_back(e);
        end
        issue_start(20, 4, 0, -1);
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < 6; b++) begin
                if (r < 2 || b < 3) send_beat(beat_word(1, r, b), 1'b0);
            end
        end
        rstn = 1'b0;
        bus.ext_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.ext_valid_i = 1'b0;
        bus.ext_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        run_load(5, 1, 0, 1'b0, 0, 7, 1'b0, -1);
        run_load(94, 4, 1, 1'b0, 0, 0, 1'b1, -1);
        run_load(40, 1, 1, 1'b0, 10, 17, 1'b0, -1);
        run_load(60, 2, 1, 1'b1, 0, 0, 1'b0, -1);
        run_load(7, 0, 1, 1'b0, 0, 0, 1'b0, -1);
        run_load(0, 96, 1, 1'b0, 0, 0, 1'b0, -1);
        run_load(50, 100, 1, 1'b0, 0, 0, 1'b0, -1);
        reset_midload();
        run_load(30, 1, 1, 1'b1, 3, 15, 1'b0, 8);
        repeat (2) @(posedge clk);
        fin = 1'b1;
    end

    // Monitor: compares every store write and done pulse against the queued expectations.
    initial begin
        int  hs_cnt;
        int  seen_id;
        int  last_wr_cyc;
        int  tok;
        wr_t e;
        hs_cnt = 0;
        seen_id = 0;
        last_wr_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hs_cnt = 0;
                total++;
                if (bus.wrif_en_o !== 1'b0 || bus.ext_ready_o !== 1'b0 || busy_o !== 1'b0 ||
                    done_o !== 1'b0 || bus.wrif_addr_o !== 7'd0 || bus.wrif_data_o !== '0) begin
                    bad++;
                    $display("FAIL reset_outs en=%b rdy=%b busy=%b done=%b addr=%0d data_zero=%b required all 0",
                             bus.wrif_en_o, bus.ext_ready_o, busy_o, done_o, bus.wrif_addr_o,
                             (bus.wrif_data_o == '0));
                end
`ifdef REF_LUMA_STAT_EN
                total++;
                if (stall_cnt_o !== 16'd0) begin
                    bad++;
                    $display("FAIL reset_stall act=%0d required=0", stall_cnt_o);
                end
`endif
            end else if (fin) begin
                total++;
                if (wq.size() != 0 || dq.size() != 0 || tmo_cnt != 0) begin
                    bad++;
                    $display("FAIL end_queues writes_left=%0d dones_left=%0d timeouts=%0d required 0/0/0",
                             wq.size(), dq.size(), tmo_cnt);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end else begin
                if (bus.ext_valid_i && bus.ext_ready_o) hs_cnt++;
                if (rd_busy_i) begin
                    total++;
                    if (bus.wrif_en_o !== 1'b0 || bus.ext_ready_o !== 1'b0) begin
                        bad++;
                        $display("FAIL rd_contention en=%b rdy=%b required 0/0",
                                 bus.wrif_en_o, bus.ext_ready_o);
                    end
                end
                if (bus.wrif_en_o === 1'b1) begin
                    total++;
                    if (wq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_write addr=%0d required none", bus.wrif_addr_o);
                    end else begin
                        e = wq.pop_front();
                        if (bus.wrif_addr_o !== e.addr) begin
                            bad++;
                            $display("FAIL wr_addr act=%0d required=%0d", bus.wrif_addr_o, e.addr);
                        end
                        total++;
                        if (bus.wrif_data_o !== e.data) begin
                            bad++;
                            $display("FAIL wr_data act=%h required=%h", bus.wrif_data_o, e.data);
                        end
                    end
                    total++;
                    if (hs_cnt != 6) begin
                        bad++;
                        $display("FAIL beats_per_row act=%0d required=6", hs_cnt);
                    end
                    hs_cnt = 0;
                    if (seen_id != load_id) begin
                        seen_id = load_id;
                        if (lat_exp > 0) begin
                            total++;
                            if (cyc - start_cyc != lat_exp) begin
                                bad++;
                                $display("FAIL first_write_latency act=%0d required=%0d",
                                         cyc - start_cyc, lat_exp);
                            end
                        end
                    end
                    last_wr_cyc = cyc;
                end
                if (done_o === 1'b1) begin
                    total++;
                    if (dq.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_done act=1 required=0");
                    end else begin
                        tok = dq.pop_front();
                        if (cyc - ((tok == 1) ? start_cyc : last_wr_cyc) != 1) begin
                            bad++;
                            $display("FAIL done_latency act=%0d required=1",
                                     cyc - ((tok == 1) ? start_cyc : last_wr_cyc));
                        end
                        total++;
                        if (wq.size() != 0) begin
                            bad++;
                            $display("FAIL writes_before_done left=%0d required=0", wq.size());
                        end
`ifdef REF_LUMA_STAT_EN
                        if (stall_exp_v >= 0) begin
                            total++;
                            if (stall_cnt_o !== 16'(stall_exp_v)) begin
                                bad++;
                                $display("FAIL stall_cnt act=%0d required=%0d", stall_cnt_o, stall_exp_v);
                            end
                        end
`endif
                    end
                end
            end
        end
    end

endmodule
